rgb_bcd_convert: RTL

- Sequential binary-to-BCD converter placed between the colour-detect stage (R_detect/G_detect/B_detect, 8-bit each) and prom_control.
- On a start pulse it samples all three channels and converts each to hundreds/tens/units digits with a shift-add-3 (double-dabble) engine.
- The engine is shared across the three channels, which are processed in the order R, G, B.
- It then commits all nine digits atomically, so the character ROM addressing never shows a half-updated value.

---
 rtl/rgb_bcd_convert.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rgb_bcd_convert.sv
// rgb_bcd_convert
//   Samples three 8-bit colour values on a start pulse and converts each one
//   to hundreds/tens/units BCD digits. A single shift-add-3 (double-dabble)
//   engine is shared by the channels in the order R, G, B. All nine output
//   digits change together on one clock edge, so downstream character-ROM
//   addressing never sees a mix of old and new digits.
//
//   Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//     when defined, leading-zero hundreds/tens digits are replaced by
//     BLANK_CODE on commit, and the reset value of hundreds/tens is
//     BLANK_CODE. When undefined, raw BCD digits are output and every digit
//     resets to 0.
//
// Ports
//   clk25                    pixel clock, all logic on the rising edge
//   rst_n                    asynchronous active-low reset
//   start                    one-cycle convert request, honoured only when idle
//   R_detect/G_detect/B_detect  8-bit channel values
//   busy                     high while a conversion is in flight
//   done                     one-cycle pulse in the cycle the digits update
//   R_h/R_d/R_u, G_h/G_d/G_u, B_h/B_d/B_u  hundreds/tens/units digits

module rgb_bcd_convert #(
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] R_detect,
    input  logic [7:0] G_detect,
    input  logic [7:0] B_detect,
    output logic       busy,
    output logic       done,
    output logic [3:0] R_h,
    output logic [3:0] R_d,
    output logic [3:0] R_u,
    output logic [3:0] G_h,
    output logic [3:0] G_d,
    output logic [3:0] G_u,
    output logic [3:0] B_h,
    output logic [3:0] B_d,
    output logic [3:0] B_u
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} state_t;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] HD_RESET = BLANK_CODE;
`else
    localparam logic [3:0] HD_RESET = 4'h0;
`endif

    state_t      state;
    logic [1:0]  ch;
    logic [2:0]  cnt;
    logic [19:0] sr;
    logic [7:0]  val_r, val_g, val_b;
    logic [11:0] shadow_r, shadow_g;
    logic [19:0] adj;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after
    // the following shift, so 3 is added first to carry into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Final digit formatting applied when the digits are committed.
    function automatic logic [11:0] format_digits(input logic [11:0] hdu);
        logic [3:0] h, d, u;
        h = hdu[11:8];
        d = hdu[7:4];
        u = hdu[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 4'd0) begin
            h = BLANK_CODE;
            if (d == 4'd0)
                d = BLANK_CODE;
        end
`endif
        return {h, d, u};
    endfunction

    assign adj = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ch       <= 2'd0;
            cnt      <= 3'd0;
            sr       <= 20'd0;
            val_r    <= 8'd0;
            val_g    <= 8'd0;
            val_b    <= 8'd0;
            shadow_r <= 12'd0;
            shadow_g <= 12'd0;
            {R_h, R_d, R_u} <= {HD_RESET, HD_RESET, 4'h0};
            {G_h, G_d, G_u} <= {HD_RESET, HD_RESET, 4'h0};
            {B_h, B_d, B_u} <= {HD_RESET, HD_RESET, 4'h0};
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        val_r <= R_detect;
                        val_g <= G_detect;
                        val_b <= B_detect;
                        ch    <= 2'd0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    case (ch)
                        2'd0:    sr <= {12'd0, val_r};
                        2'd1:    sr <= {12'd0, val_g};
                        default: sr <= {12'd0, val_b};
                    endcase
                    cnt   <= 3'd0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr  <= {adj[18:0], 1'b0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= STORE;
                end
                STORE: begin
                    if (ch < 2'd2) begin
                        if (ch == 2'd0)
                            shadow_r <= sr[19:8];
                        else
                            shadow_g <= sr[19:8];
                        ch    <= ch + 2'd1;
                        state <= LOAD;
                    end else begin
                        // The blue result goes straight from the shift
                        // register; the output registers update on this
                        // edge so they are valid alongside the done pulse.
                        {R_h, R_d, R_u} <= format_digits(shadow_r);
                        {G_h, G_d, G_u} <= format_digits(shadow_g);
                        {B_h, B_d, B_u} <= format_digits(sr[19:8]);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
